// File: rtl/sdram_read.sv
// sdram_read: fetches full-page SDRAM read bursts and packs halfword pairs into 32-bit FIFO words.
// Define SDRAM_READ_INPUT_REG_EN to register data_in once before capture (adds one cycle of latency).

`ifndef SDRAM_CMD_NOP
`define SDRAM_CMD_NOP       3'b111
`define SDRAM_CMD_ACTIVE    3'b011
`define SDRAM_CMD_READ      3'b101
`define SDRAM_CMD_WRITE     3'b100
`define SDRAM_CMD_TERM      3'b110
`define SDRAM_CMD_PRECHARGE 3'b010
`define SDRAM_CMD_REFRESH   3'b001
`define SDRAM_CMD_LOAD_MODE 3'b000
`endif
`ifndef T_CAS
`define T_CAS 2
`endif
`ifndef T_RCD
`define T_RCD 2
`endif
`ifndef T_RP
`define T_RP 2
`endif

// FIFO handshake: fifo_ready asks for a buffer to be filled; fifo_activate stays high while this
// block owns the buffer and drops once word_count reaches fifo_size; fifo_inactive allows IDLE.
module sdram_read (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  command,
  output logic [11:0] address,
  output logic [1:0]  bank,
  input  logic [15:0] data_in,
  output logic [1:0]  data_mask,
  output logic        idle,
  input  logic        enable,
  input  logic [21:0] app_address,
  input  logic        auto_refresh,
  output logic        wait_for_refresh,
  output logic [31:0] fifo_data,
  output logic        fifo_write,
  input  logic        fifo_ready,
  output logic        fifo_activate,
  input  logic [23:0] fifo_size,
  input  logic        fifo_inactive,
  output logic [2:0]  debug_state
);

`ifdef SDRAM_READ_INPUT_REG_EN
  localparam int CAP_DEPTH = `T_CAS + 1;
`else
  localparam int CAP_DEPTH = `T_CAS;
`endif

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    WAIT            = 3'd1,
    ACTIVATE        = 3'd2,
    READ_COMMAND    = 3'd3,
    READ_BURST      = 3'd4,
    BURST_TERMINATE = 3'd5,
    DRAIN           = 3'd6,
    PRECHARGE       = 3'd7
  } state_t;

  state_t         state, state_n;
  logic [3:0]     delay, delay_n;
  logic [2:0]     command_n;
  logic [11:0]    address_n;
  logic [1:0]     bank_n;
  logic           wfr_n, fa_n;
  logic [23:0]    word_count, wc_n;
  logic [21:0]    read_address, ra_n;
  logic [7:0]     col_next;
  logic           bottom_half, bottom_n;
  // req_valid/req_bottom mark the halfword request currently on the bus
  logic           req_valid, req_valid_n, req_bottom, req_bottom_n;
  logic [CAP_DEPTH-1:0] valid_sr, bottom_sr;
  logic [15:0]    top_hold, cap_data;

  assign data_mask   = 2'b00;
  assign debug_state = state;
  assign idle        = (delay == 4'd0) && ((state == IDLE) || (state == WAIT));
  assign col_next    = read_address[7:0] + 8'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      delay            <= '0;
      command          <= `SDRAM_CMD_NOP;
      address          <= '0;
      bank             <= '0;
      wait_for_refresh <= 1'b0;
      fifo_activate    <= 1'b0;
      word_count       <= '0;
      read_address     <= '0;
      bottom_half      <= 1'b0;
      req_valid        <= 1'b0;
      req_bottom       <= 1'b0;
    end else begin
      state            <= state_n;
      delay            <= delay_n;
      command          <= command_n;
      address          <= address_n;
      bank             <= bank_n;
      wait_for_refresh <= wfr_n;
      fifo_activate    <= fa_n;
      word_count       <= wc_n;
      read_address     <= ra_n;
      bottom_half      <= bottom_n;
      req_valid        <= req_valid_n;
      req_bottom       <= req_bottom_n;
    end
  end

  always_comb begin
    state_n      = state;
    delay_n      = delay;
    command_n    = `SDRAM_CMD_NOP;
    address_n    = address;
    bank_n       = bank;
    wfr_n        = 1'b0;
    fa_n         = fifo_activate;
    wc_n         = word_count;
    ra_n         = read_address;
    bottom_n     = bottom_half;
    req_valid_n  = 1'b0;
    req_bottom_n = 1'b0;
    if (delay != 4'd0) begin
      delay_n = delay - 4'd1;
    end else begin
      case (state)
        IDLE: begin
          wfr_n = 1'b1;
          if (enable || fifo_ready) begin
            ra_n    = app_address;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (auto_refresh) begin
            wfr_n = 1'b1;
          end else if (!fifo_activate) begin
            if (fifo_ready) begin
              fa_n = 1'b1;
              wc_n = '0;
            end else if (fifo_inactive && !enable) begin
              state_n = IDLE;
            end
          end else if (word_count >= fifo_size) begin
            fa_n    = 1'b0;
            delay_n = 4'd1;
          end else begin
            state_n = ACTIVATE;
          end
        end
        ACTIVATE: begin
          command_n = `SDRAM_CMD_ACTIVE;
          bank_n    = read_address[21:20];
          address_n = read_address[19:8];
          delay_n   = 4'(`T_RCD);
          state_n   = READ_COMMAND;
        end
        READ_COMMAND: begin
          command_n   = `SDRAM_CMD_READ;
          address_n   = {4'b0000, read_address[7:0]};
          req_valid_n = 1'b1;
          bottom_n    = 1'b1;
          state_n     = READ_BURST;
        end
        READ_BURST: begin
          // the burst continues on NOP; each cycle requests the next halfword
          req_valid_n  = 1'b1;
          req_bottom_n = bottom_half;
          if (bottom_half) begin
            ra_n     = read_address + 22'd2;
            wc_n     = word_count + 24'd1;
            bottom_n = 1'b0;
            if ((wc_n >= fifo_size) || (col_next == 8'h00) || auto_refresh)
              state_n = BURST_TERMINATE;
          end else begin
            bottom_n = 1'b1;
          end
        end
        BURST_TERMINATE: begin
          command_n = `SDRAM_CMD_TERM;
          state_n   = DRAIN;
        end
        DRAIN: begin
          if (!req_valid && (valid_sr == '0)) state_n = PRECHARGE;
        end
        PRECHARGE: begin
          command_n = `SDRAM_CMD_PRECHARGE;
          delay_n   = 4'(`T_RP);
          state_n   = WAIT;
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef SDRAM_READ_INPUT_REG_EN
  logic [15:0] data_q;
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_in;
  end
  assign cap_data = data_q;
`else
  assign cap_data = data_in;
`endif

  // Tags follow each request down the CAS pipeline; the last stage lines up with its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr   <= '0;
      bottom_sr  <= '0;
      top_hold   <= '0;
      fifo_data  <= '0;
      fifo_write <= 1'b0;
    end else begin
      valid_sr   <= (valid_sr << 1) | CAP_DEPTH'(req_valid);
      bottom_sr  <= (bottom_sr << 1) | CAP_DEPTH'(req_bottom);
      fifo_write <= 1'b0;
      if (valid_sr[CAP_DEPTH-1]) begin
        if (bottom_sr[CAP_DEPTH-1]) begin
          fifo_data  <= {top_hold, cap_data};
          fifo_write <= 1'b1;
        end else begin
          top_hold <= cap_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: directed bench for sdram_read with a CAS-latency SDRAM read model.
// Works with SDRAM_READ_INPUT_REG_EN defined or not; only the write latency expectation changes.

`ifndef SDRAM_CMD_NOP
`define SDRAM_CMD_NOP       3'b111
`define SDRAM_CMD_ACTIVE    3'b011
`define SDRAM_CMD_READ      3'b101
`define SDRAM_CMD_WRITE     3'b100
`define SDRAM_CMD_TERM      3'b110
`define SDRAM_CMD_PRECHARGE 3'b010
`define SDRAM_CMD_REFRESH   3'b001
`define SDRAM_CMD_LOAD_MODE 3'b000
`endif
`ifndef T_CAS
`define T_CAS 2
`endif

module tb_sdram_read;
  localparam logic [2:0] CMD_NOP  = `SDRAM_CMD_NOP;
  localparam logic [2:0] CMD_ACT  = `SDRAM_CMD_ACTIVE;
  localparam logic [2:0] CMD_READ = `SDRAM_CMD_READ;
  localparam logic [2:0] CMD_TERM = `SDRAM_CMD_TERM;
  localparam logic [2:0] CMD_PRE  = `SDRAM_CMD_PRECHARGE;
  localparam int CAS_LAT = `T_CAS;
`ifdef SDRAM_READ_INPUT_REG_EN
  localparam int WRITE_LAT = `T_CAS + 3;
`else
  localparam int WRITE_LAT = `T_CAS + 2;
`endif
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  command;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_in = 16'h0000;
  logic [1:0]  data_mask;
  logic        idle;
  logic        enable = 1'b0;
  logic [21:0] app_address = '0;
  logic        auto_refresh = 1'b0;
  logic        wait_for_refresh;
  logic [31:0] fifo_data;
  logic        fifo_write;
  logic        fifo_ready = 1'b0;
  logic        fifo_activate;
  logic [23:0] fifo_size = '0;
  logic        fifo_inactive = 1'b1;
  logic [2:0]  debug_state;

  sdram_read dut (
    .clk(clk), .rst(rst), .command(command), .address(address), .bank(bank),
    .data_in(data_in), .data_mask(data_mask), .idle(idle), .enable(enable),
    .app_address(app_address), .auto_refresh(auto_refresh),
    .wait_for_refresh(wait_for_refresh), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_ready(fifo_ready), .fifo_activate(fifo_activate), .fifo_size(fifo_size),
    .fifo_inactive(fifo_inactive), .debug_state(debug_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // bus monitor and SDRAM read model (full-page burst, stops on TERM/PRE)
  int cycle = 0;
  logic [31:0] got_q[$];
  int write_cyc_q[$];
  int read_cyc_q[$];
  logic [11:0] act_row_q[$];
  logic [7:0]  read_col_q[$];
  int term_cnt = 0, pre_cnt = 0, fa_cnt = 0, gap_viol = 0;
  logic        streaming = 1'b0;
  logic [11:0] mdl_row = '0;
  logic [7:0]  mdl_col = '0;
  logic [15:0] pipe[CAS_LAT] = '{default: 16'h0000};

  function automatic logic [15:0] model_hw(input logic [11:0] row, input logic [7:0] col);
    logic [3:0] n;
    n = 4'(col - 8'h0F);
    if (row == 12'd0 && col >= 8'h10 && col <= 8'h17) return {n, n, n, n};
    return {row[3:0], 4'hA, col};
  endfunction

  always @(negedge clk) begin
    logic [15:0] cur;
    cycle++;
    cur = 16'hDEAD;
    if (rst) begin
      streaming = 1'b0;
    end else begin
      case (command)
        CMD_ACT:  begin mdl_row = address; act_row_q.push_back(address); end
        CMD_READ: begin
          streaming = 1'b1;
          mdl_col = address[7:0];
          read_col_q.push_back(address[7:0]);
          read_cyc_q.push_back(cycle);
        end
        CMD_TERM: begin streaming = 1'b0; term_cnt++; end
        CMD_PRE:  begin streaming = 1'b0; pre_cnt++; end
        default: ;
      endcase
      if (fifo_activate) fa_cnt++;
      if (fifo_write) begin
        if (write_cyc_q.size() > 0 && (cycle - write_cyc_q[$]) < 2) gap_viol++;
        got_q.push_back(fifo_data);
        write_cyc_q.push_back(cycle);
      end
    end
    if (streaming) begin
      cur = model_hw(mdl_row, mdl_col);
      mdl_col++;
    end
    data_in = pipe[CAS_LAT-1];
    for (int k = CAS_LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = cur;
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_words(input string tag, input int w0);
    int i;
    logic [31:0] e;
    logic [31:0] o;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (w0 + i < got_q.size()) ? got_q[w0 + i] : 32'hxxxx_xxxx;
      check($sformatf("%s_word%0d", tag, i), o, e);
      i++;
    end
  endtask

  task automatic start_read(input string tag, input logic [21:0] addr, input logic [23:0] size);
    int n;
    app_address = addr;
    fifo_size = size;
    fifo_ready = 1'b1;
    n = 0;
    while (fifo_activate !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    fifo_ready = 1'b0;
    check({tag, "_activate_seen"}, (n < 50) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (debug_state !== ST_IDLE && n < budget) begin @(negedge clk); n++; end
    check({tag, "_back_to_idle"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0, r0, t0, p0, f0, n;

    repeat (3) @(negedge clk);
    check("rst_command", 32'(command), 32'(CMD_NOP));
    check("rst_address", 32'(address), 32'd0);
    check("rst_bank", 32'(bank), 32'd0);
    check("rst_data_mask", 32'(data_mask), 32'd0);
    check("rst_fifo_data", fifo_data, 32'd0);
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_fifo_activate", 32'(fifo_activate), 32'd0);
    check("rst_wait_for_refresh", 32'(wait_for_refresh), 32'd0);
    check("rst_state", 32'(debug_state), 32'(ST_IDLE));
    check("rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_wfr_pulse", 32'(wait_for_refresh), 32'd1);

    // single row, four words
    w0 = got_q.size(); a0 = act_row_q.size(); r0 = read_col_q.size(); t0 = term_cnt; p0 = pre_cnt;
    start_read("t1", 22'h000010, 24'd4);
    wait_idle("t1", 400);
    exp_q = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    check("t1_writes", got_q.size() - w0, 32'd4);
    check_words("t1", w0);
    check("t1_acts", act_row_q.size() - a0, 32'd1);
    check("t1_terms", term_cnt - t0, 32'd1);
    check("t1_pres", pre_cnt - p0, 32'd1);
    check("t1_read_col", (read_col_q.size() > r0) ? 32'(read_col_q[r0]) : 32'hFFFF, 32'h10);
    check("t1_latency", (write_cyc_q.size() > w0 && read_cyc_q.size() > r0) ?
          32'(write_cyc_q[w0] - read_cyc_q[r0]) : 32'hFFFF, 32'(WRITE_LAT));
    check("t1_write_gap", gap_viol, 32'd0);

    // column wrap into next row
    w0 = got_q.size(); a0 = act_row_q.size(); r0 = read_col_q.size(); t0 = term_cnt; p0 = pre_cnt;
    start_read("t2", 22'h0000FC, 24'd4);
    wait_idle("t2", 400);
    exp_q = '{32'h0AFC0AFD, 32'h0AFE0AFF, 32'h1A001A01, 32'h1A021A03};
    check("t2_writes", got_q.size() - w0, 32'd4);
    check_words("t2", w0);
    check("t2_acts", act_row_q.size() - a0, 32'd2);
    check("t2_terms", term_cnt - t0, 32'd2);
    check("t2_pres", pre_cnt - p0, 32'd2);
    check("t2_second_row", (act_row_q.size() > a0 + 1) ? 32'(act_row_q[a0+1]) : 32'hFFFF, 32'd1);
    check("t2_second_col", (read_col_q.size() > r0 + 1) ? 32'(read_col_q[r0+1]) : 32'hFFFF, 32'h00);

    // refresh interrupts a burst after word 2 of 8
    w0 = got_q.size(); a0 = act_row_q.size(); r0 = read_col_q.size(); t0 = term_cnt; p0 = pre_cnt;
    start_read("t3", 22'h000020, 24'd8);
    n = 0;
    while (command !== CMD_READ && n < 50) begin @(negedge clk); n++; end
    check("t3_read_seen", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    auto_refresh = 1'b1;
    n = 0;
    while (wait_for_refresh !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("t3_wfr_seen", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    check("t3_wfr_state", 32'(debug_state), 32'(ST_WAIT));
    check("t3_writes_at_refresh", got_q.size() - w0, 32'd2);
    check("t3_terms_at_refresh", term_cnt - t0, 32'd1);
    check("t3_pres_at_refresh", pre_cnt - p0, 32'd1);
    auto_refresh = 1'b0;
    wait_idle("t3", 600);
    exp_q = '{32'h0A200A21, 32'h0A220A23, 32'h0A240A25, 32'h0A260A27,
              32'h0A280A29, 32'h0A2A0A2B, 32'h0A2C0A2D, 32'h0A2E0A2F};
    check("t3_writes", got_q.size() - w0, 32'd8);
    check_words("t3", w0);
    check("t3_acts", act_row_q.size() - a0, 32'd2);
    check("t3_resume_col", (read_col_q.size() > r0 + 1) ? 32'(read_col_q[r0+1]) : 32'hFFFF, 32'h24);
    check("t3_write_gap", gap_viol, 32'd0);

    // zero free space: activate for one cycle, no row opened
    w0 = got_q.size(); a0 = act_row_q.size(); f0 = fa_cnt;
    start_read("t4", 22'h000030, 24'd0);
    wait_idle("t4", 100);
    check("t4_activate_cycles", fa_cnt - f0, 32'd1);
    check("t4_acts", act_row_q.size() - a0, 32'd0);
    check("t4_writes", got_q.size() - w0, 32'd0);

    // reset in the middle of a burst
    w0 = got_q.size();
    start_read("t5", 22'h000040, 24'd8);
    n = 0;
    while (got_q.size() < w0 + 2 && n < 100) begin @(negedge clk); n++; end
    check("t5_writes_before_rst", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    exp_q = '{32'h0A400A41, 32'h0A420A43};
    check_words("t5", w0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_command", 32'(command), 32'(CMD_NOP));
    check("t5_rst_fifo_write", 32'(fifo_write), 32'd0);
    check("t5_rst_fifo_activate", 32'(fifo_activate), 32'd0);
    check("t5_rst_state", 32'(debug_state), 32'(ST_IDLE));
    rst = 1'b0;
    w0 = got_q.size();
    repeat (30) @(negedge clk);
    check("t5_no_writes_after_rst", got_q.size() - w0, 32'd0);
    check("t5_state_after_rst", 32'(debug_state), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
